// File: rtl/fetch_stage.sv
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : PC / instruction-memory fetch with one-entry stall buffer and
//             IF/ID pipeline register feeding decode.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'hFC00_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Stall_F,
   input  logic        Stall_D,
   input  logic        Flush_D,
   input  logic        Jump_D,
   input  logic        PC_src_D,
   input  logic [31:0] Jump_target_D,
   input  logic [31:0] Branch_target_D,
   output logic        Imem_req,
   output logic [31:0] Imem_addr,
   input  logic [31:0] Imem_rdata,
   input  logic        Imem_ready,
   output logic [31:0] Instr_D,
   output logic [31:0] PC_D,
   output logic [31:0] PC_plus4_D,
   output logic        Valid_D
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_buf;
   logic [31:0] r_instr;
   logic [31:0] r_pc_d;
   logic [31:0] r_pc4_d;
   logic        r_valid;

   logic        w_redirect;
   logic [31:0] w_target;
   logic        w_stall;
   logic [31:0] w_pc_plus4;
   logic        w_load;
   logic [31:0] w_load_data;
   logic        w_wait_bubble;

   assign w_redirect = Jump_D | PC_src_D;
   assign w_target   = (Jump_D ? Jump_target_D : Branch_target_D) & 32'hFFFF_FFFC;
   assign w_stall    = Stall_F | Stall_D;
   assign w_pc_plus4 = r_pc + 32'd4;

   // w_load: a fetched instruction is ready to enter IF/ID this edge.
   always_comb begin
      w_load        = 1'b0;
      w_load_data   = r_buf;
      w_wait_bubble = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (Imem_ready && !w_stall) begin
               w_load      = 1'b1;
               w_load_data = Imem_rdata;
            end else if (!Imem_ready && !w_stall) begin
               w_wait_bubble = 1'b1;
            end
         end
         S_HOLD: begin
            if (!w_stall) begin
               w_load = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_buf   <= 32'd0;
         r_instr <= NOP_INSTR;
         r_pc_d  <= 32'd0;
         r_pc4_d <= 32'd0;
         r_valid <= 1'b0;
      end else begin
         if (w_redirect) begin
            r_pc    <= w_target;
            r_buf   <= 32'd0;
            r_state <= S_FETCH;
         end else begin
            case (r_state)
               S_IDLE: r_state <= S_FETCH;
               S_FETCH: begin
                  if (Imem_ready) begin
                     if (w_stall) begin
                        r_buf   <= Imem_rdata;
                        r_state <= S_HOLD;
                     end else begin
                        r_pc <= w_pc_plus4;
                     end
                  end
               end
               S_HOLD: begin
                  if (!w_stall) begin
                     r_pc    <= w_pc_plus4;
                     r_state <= S_FETCH;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end

         // IF/ID: bubble beats hold beats load; otherwise contents persist.
         if (Flush_D || w_redirect || w_wait_bubble) begin
            r_instr <= NOP_INSTR;
            r_pc_d  <= 32'd0;
            r_pc4_d <= 32'd0;
            r_valid <= 1'b0;
         end else if (!Stall_D && w_load) begin
            r_instr <= w_load_data;
            r_pc_d  <= r_pc;
            r_pc4_d <= w_pc_plus4;
            r_valid <= 1'b1;
         end
      end
   end

   assign Imem_req   = (r_state == S_FETCH);
   assign Imem_addr  = r_pc;
   assign Instr_D    = r_instr;
   assign PC_D       = r_pc_d;
   assign PC_plus4_D = r_pc4_d;
   assign Valid_D    = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Directed self-checking bench for fetch_stage.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

   localparam logic [31:0] c_NOP = 32'hFC00_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        Stall_F, Stall_D, Flush_D, Jump_D, PC_src_D;
   logic [31:0] Jump_target_D, Branch_target_D;
   logic        Imem_ready;
   logic        Imem_req, Valid_D;
   logic [31:0] Imem_addr, Imem_rdata, Instr_D, PC_D, PC_plus4_D;
   logic        req2, valid2;
   logic [31:0] addr2, rdata2, instr2, pcd2, pc4d2;

   int n_pass  = 0;
   int n_total = 0;
   bit cmp_en  = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA500_0000;
   endfunction

   assign Imem_rdata = mem_word(Imem_addr);
   assign rdata2     = mem_word(addr2);

   fetch_stage dut (
      .clk(clk), .rst(rst), .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D),
      .Jump_D(Jump_D), .PC_src_D(PC_src_D), .Jump_target_D(Jump_target_D),
      .Branch_target_D(Branch_target_D), .Imem_req(Imem_req), .Imem_addr(Imem_addr),
      .Imem_rdata(Imem_rdata), .Imem_ready(Imem_ready), .Instr_D(Instr_D), .PC_D(PC_D),
      .PC_plus4_D(PC_plus4_D), .Valid_D(Valid_D)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .rst(rst), .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D),
      .Jump_D(Jump_D), .PC_src_D(PC_src_D), .Jump_target_D(Jump_target_D),
      .Branch_target_D(Branch_target_D), .Imem_req(req2), .Imem_addr(addr2),
      .Imem_rdata(rdata2), .Imem_ready(Imem_ready), .Instr_D(instr2), .PC_D(pcd2),
      .PC_plus4_D(pc4d2), .Valid_D(valid2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: "running" / "word held" view of the fetch unit plus expected IF/ID.
   logic [31:0] m_pc, m_word, e_instr, e_pc, e_pc4;
   bit          m_run, m_held, e_valid;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc = 32'h0; m_word = 32'h0; m_run = 0; m_held = 0;
         e_instr = c_NOP; e_pc = 0; e_pc4 = 0; e_valid = 0;
      end else begin
         bit          redir, stall, bubble, have_new;
         logic [31:0] tgt, nw, npc;
         redir    = Jump_D | PC_src_D;
         tgt      = Jump_D ? {Jump_target_D[31:2], 2'b00} : {Branch_target_D[31:2], 2'b00};
         stall    = Stall_F | Stall_D;
         bubble   = Flush_D | redir;
         have_new = 0;
         nw       = 0;
         npc      = m_pc;
         if (redir) begin
            m_pc = tgt; m_held = 0; m_run = 1;
         end else if (!m_run) begin
            m_run = 1;
         end else if (m_held) begin
            if (!stall) begin
               have_new = 1; nw = m_word; m_held = 0; m_pc = m_pc + 32'd4;
            end
         end else if (Imem_ready) begin
            if (!stall) begin
               have_new = 1; nw = mem_word(m_pc); m_pc = m_pc + 32'd4;
            end else begin
               m_held = 1; m_word = mem_word(m_pc);
            end
         end else if (!stall) begin
            bubble = 1;
         end
         if (bubble) begin
            e_instr = c_NOP; e_pc = 0; e_pc4 = 0; e_valid = 0;
         end else if (have_new) begin
            e_instr = nw; e_pc = npc; e_pc4 = npc + 32'd4; e_valid = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en && !rst) begin
         chk("req",   {31'd0, Imem_req}, {31'd0, m_run && !m_held});
         chk("addr",  Imem_addr, m_pc);
         chk("instr", Instr_D, e_instr);
         chk("pc_d",  PC_D, e_pc);
         chk("pc4_d", PC_plus4_D, e_pc4);
         chk("valid", {31'd0, Valid_D}, {31'd0, e_valid});
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; Stall_F = 0; Stall_D = 0; Flush_D = 0; Jump_D = 0; PC_src_D = 0;
      Jump_target_D = 0; Branch_target_D = 0; Imem_ready = 1'b1;
      #2;
      chk("rst_instr", Instr_D, 32'hFC00_0000);
      chk("rst_valid", {31'd0, Valid_D}, 32'd0);
      chk("rst_req",   {31'd0, Imem_req}, 32'd0);
      chk("rst_addr2", addr2, 32'hFFFF_FFFC);
      step(); step();
      rst = 1'b0; cmp_en = 1'b1;
      step();                                   // IDLE -> FETCH
      chk("n1_req", {31'd0, Imem_req}, 32'd1);
      chk("n1_addr", Imem_addr, 32'h0);
      step();
      chk("n2_instr", Instr_D, 32'hA500_0000);
      chk("n2_addr", Imem_addr, 32'h4);
      chk("w_addr2", addr2, 32'h0);
      chk("w_pcd2", pcd2, 32'hFFFF_FFFC);
      chk("w_pc4d2", pc4d2, 32'h0);
      chk("w_instr2", instr2, 32'h5AFF_FFFC);
      step();
      chk("n3_pc4", PC_plus4_D, 32'h8);
      Imem_ready = 1'b0;                        // 3 wait cycles at PC=8
      step();
      chk("wait_bubble", Instr_D, 32'hFC00_0000);
      step(); step();
      chk("wait_addr", Imem_addr, 32'h8);
      Imem_ready = 1'b1;
      step();
      chk("after_wait", Instr_D, 32'hA500_0008);
      Stall_F = 1'b1;                           // word at 12 gets buffered
      step();
      chk("hold_req", {31'd0, Imem_req}, 32'd0);
      step();
      chk("hold_instr", Instr_D, 32'hA500_0008);
      Stall_F = 1'b0;
      step();
      chk("rel_instr", Instr_D, 32'hA500_000C);
      chk("rel_addr", Imem_addr, 32'h10);
      Jump_D = 1; Jump_target_D = 32'h0000_0103; PC_src_D = 1; Branch_target_D = 32'h40;
      step();
      chk("jmp_addr", Imem_addr, 32'h100);
      chk("jmp_valid", {31'd0, Valid_D}, 32'd0);
      Jump_D = 0; PC_src_D = 0;
      step();
      chk("jmp_instr", Instr_D, 32'hA500_0100);
      Flush_D = 1; Stall_D = 1;
      step();
      chk("fl_valid", {31'd0, Valid_D}, 32'd0);
      chk("fl_addr", Imem_addr, 32'h104);
      Flush_D = 0; Stall_D = 0;
      step();
      chk("fl_rel", Instr_D, 32'hA500_0104);
      Stall_F = 1;
      step();
      PC_src_D = 1; Branch_target_D = 32'h0000_0202;   // redirect while stalled in HOLD
      step();
      chk("br_addr", Imem_addr, 32'h200);
      chk("br_req", {31'd0, Imem_req}, 32'd1);
      PC_src_D = 0; Stall_F = 0;
      step();
      chk("br_instr", Instr_D, 32'hA500_0200);
      Imem_ready = 0;
      step();
      #2 rst = 1'b1;                            // async reset mid-wait
      #1;
      chk("ar_instr", Instr_D, 32'hFC00_0000);
      chk("ar_valid", {31'd0, Valid_D}, 32'd0);
      chk("ar_addr",  Imem_addr, 32'h0);
      chk("ar_pcd",   PC_D, 32'h0);
      chk("ar_req",   {31'd0, Imem_req}, 32'd0);
      step();
      rst = 1'b0; Imem_ready = 1'b1;
      step(); step(); step();
      chk("post_rst", Instr_D, 32'hA500_0004);
      step();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
